dvs_event_unpacker: RTL and testbench
=====================================

DVS_EVENT_UNPACKER -- requirements
Module: dvs_event_unpacker

Interface
REQ-001 Parameter X_BITS, default DVS_X_ADDR_BITS: width of the packed X address field.
REQ-002 Parameter Y_BITS, default DVS_Y_ADDR_BITS: width of the packed Y address field.
REQ-003 Parameter TS_BITS, default TIMESTAMP_US_BITS: width of the microsecond timestamp field.
REQ-004 Parameter CNT_BITS, default 16: width of the statistics counters.
REQ-005 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 clear  input  1  synchronous clear of the timestamp history and both counters.
REQ-009 in_valid  input  1  a packed event is presented.
REQ-010 in_ready  output  1  the unpacker accepts the packed event this cycle.
REQ-011 in_event  input  X_BITS+Y_BITS+1+TS_BITS  packed event, laid out as {x, y, polarity, timestamp} from MSB to LSB.
REQ-012 in_filtered  input  1  the event was rejected by the preprocessor and is discarded.
REQ-013 out_valid / out_ready  output / input  1 each  output handshake.
REQ-014 out_x, out_y, out_pol  output  X_BITS, Y_BITS, 1  unpacked event fields.
REQ-015 out_dt  output  TS_BITS  timestamp delta since the previous forwarded event.
REQ-016 out_first  output  1  this is the first event forwarded since reset or clear.
REQ-017 drop_count, fwd_count  output  CNT_BITS each  number of filtered events and number of forwarded events.

Function
REQ-018 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-019 The field split SHALL be: x is the top X_BITS bits, then y, then polarity, then timestamp in the low TS_BITS bits.
REQ-020 A transferred event with in_filtered=1 SHALL be discarded: it produces no output, leaves the timestamp history unchanged, and increments drop_count.
REQ-021 Each transferred unfiltered event SHALL get out_dt = (timestamp - last_ts) mod 2^TS_BITS; last_ts then becomes its timestamp and fwd_count increments.
REQ-022 While first_pending is 1, an unfiltered event SHALL get out_dt=0 and out_first=1, and first_pending SHALL then clear.
REQ-023 The datapath SHALL be a 2-entry buffer made of an output register plus a skid register, with states EMPTY, ONE and TWO.
REQ-024 in_ready SHALL equal a registered "not TWO" flag, with no combinational path from out_ready to in_ready.
REQ-025 EMPTY SHALL go to ONE on an unfiltered input transfer; in EMPTY, out_valid=0.
REQ-026 In ONE, an unfiltered input transfer together with an output transfer SHALL stay in ONE.
REQ-027 In ONE, an unfiltered input transfer without an output transfer SHALL go to TWO, storing the event in the skid register.
REQ-028 In ONE, an output transfer without an unfiltered input transfer SHALL go to EMPTY.
REQ-029 In TWO, an output transfer SHALL move the skid register into the output register and go to ONE; no input is accepted while in TWO.
REQ-030 Latency SHALL be 1 cycle: an event accepted in cycle N is presented on the output in cycle N+1 when the buffer was EMPTY, or when it was ONE with out_ready=1.
REQ-031 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 Ordering SHALL be preserved and no event may be lost or duplicated.
REQ-033 Both counters SHALL saturate at 2^CNT_BITS-1 and never wrap.
REQ-034 clear SHALL set first_pending=1 and zero both counters; it does not flush buffered events.
REQ-035 An event accepted in the same cycle as clear SHALL be treated as a first event, and no counter increments in that cycle.

Reset
REQ-036 Reset SHALL force state EMPTY, out_valid=0, in_ready=1, first_pending=1, last_ts=0, drop_count=0, fwd_count=0, and all out_* data outputs to 0.
REQ-037 Reset asserted mid-operation SHALL discard buffered events immediately, without waiting for a clock edge.

Verification
REQ-038 Reset, then send an unfiltered event with x=5, y=7, pol=1, ts=1000, with out_ready=1 -> next cycle out_valid=1, x=5, y=7, pol=1, dt=0, first=1, fwd_count=1.
REQ-039 Send events with ts=1000, 1250 and 1250, all with out_ready=1 -> dt=0, 250 and 0; first=1 only on the first event.
REQ-040 With TS_BITS=16, send ts=65530 then ts=4 -> second event has dt=10.
REQ-041 Send three events alternating in_filtered=1 and 0 (1, 0, 1) -> one output, drop_count=2, dt computed from the previous unfiltered event.
REQ-042 Hold out_ready=0 and offer 3 events back-to-back -> first two accepted, in_ready=0 on the third cycle; raise out_ready -> events emerge in order with no loss.
REQ-043 Assert clear while in state TWO -> both buffered events are still delivered, counters read 0, and the next accepted event has first=1 and dt=0; separately, force drop_count to 65535 with CNT_BITS=16 and drop once more -> drop_count stays 65535.

Source files
------------

// File: rtl/dvs_event_unpacker.sv
// DVS event unpacker: splits packed address events, derives timestamp deltas,
// and buffers them in a 2-entry output/skid pair with drop/forward statistics.
package dvs_pkg;
  localparam int DVS_X_ADDR_BITS   = 9;
  localparam int DVS_Y_ADDR_BITS   = 9;
  localparam int TIMESTAMP_US_BITS = 16;
endpackage

module dvs_event_unpacker
  import dvs_pkg::*;
#(
  parameter int X_BITS   = DVS_X_ADDR_BITS,
  parameter int Y_BITS   = DVS_Y_ADDR_BITS,
  parameter int TS_BITS  = TIMESTAMP_US_BITS,
  parameter int CNT_BITS = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [X_BITS+Y_BITS+TS_BITS:0]  in_event,
  input  logic                            in_filtered,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [X_BITS-1:0]               out_x,
  output logic [Y_BITS-1:0]               out_y,
  output logic                            out_pol,
  output logic [TS_BITS-1:0]              out_dt,
  output logic                            out_first,
  output logic [CNT_BITS-1:0]             drop_count,
  output logic [CNT_BITS-1:0]             fwd_count
);

  localparam int EW = X_BITS + Y_BITS + 1 + TS_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_e;

  typedef struct packed {
    logic [X_BITS-1:0]  x;
    logic [Y_BITS-1:0]  y;
    logic               pol;
    logic [TS_BITS-1:0] dt;
    logic               first;
  } ev_t;

  state_e state_q, state_d;
  ev_t    out_q, out_d;
  ev_t    skid_q, skid_d;
  ev_t    new_ev;
  logic   rdy_q;
  logic   first_q, first_d;
  logic [TS_BITS-1:0]  last_ts_q, last_ts_d;
  logic [CNT_BITS-1:0] drop_q, drop_d;
  logic [CNT_BITS-1:0] fwd_q, fwd_d;

  logic               acc;
  logic               acc_fwd;
  logic               acc_drop;
  logic               out_xfer;
  logic               first_now;
  logic [TS_BITS-1:0] in_ts;

  assign acc       = in_valid & rdy_q;
  assign acc_fwd   = acc & ~in_filtered;
  assign acc_drop  = acc & in_filtered;
  assign out_xfer  = (state_q != S_EMPTY) & out_ready;
  assign in_ts     = in_event[TS_BITS-1:0];
  // An event arriving with clear counts as the start of a new history.
  assign first_now = first_q | clear;

  always_comb begin
    new_ev       = '0;
    new_ev.x     = in_event[EW-1 -: X_BITS];
    new_ev.y     = in_event[TS_BITS+1 +: Y_BITS];
    new_ev.pol   = in_event[TS_BITS];
    new_ev.dt    = first_now ? '0 : in_ts - last_ts_q;
    new_ev.first = first_now;
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (acc_fwd) begin
          out_d   = new_ev;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (acc_fwd && out_xfer) begin
          out_d = new_ev;
        end else if (acc_fwd) begin
          skid_d  = new_ev;
          state_d = S_TWO;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          out_d   = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    last_ts_d = acc_fwd ? in_ts : last_ts_q;
    first_d   = first_q;
    if (acc_fwd) begin
      first_d = 1'b0;
    end else if (clear) begin
      first_d = 1'b1;
    end
    drop_d = drop_q;
    fwd_d  = fwd_q;
    if (clear) begin
      drop_d = '0;
      fwd_d  = '0;
    end else begin
      if (acc_drop && drop_q != CNT_MAX) begin
        drop_d = drop_q + 1'b1;
      end
      if (acc_fwd && fwd_q != CNT_MAX) begin
        fwd_d = fwd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      rdy_q     <= 1'b1;
      first_q   <= 1'b1;
      last_ts_q <= '0;
      drop_q    <= '0;
      fwd_q     <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      rdy_q     <= (state_d != S_TWO);
      first_q   <= first_d;
      last_ts_q <= last_ts_d;
      drop_q    <= drop_d;
      fwd_q     <= fwd_d;
    end
  end

  assign in_ready   = rdy_q;
  assign out_valid  = (state_q != S_EMPTY);
  assign out_x      = out_q.x;
  assign out_y      = out_q.y;
  assign out_pol    = out_q.pol;
  assign out_dt     = out_q.dt;
  assign out_first  = out_q.first;
  assign drop_count = drop_q;
  assign fwd_count  = fwd_q;

endmodule

// File: tb/tb_dvs_event_unpacker.sv
// Bench for dvs_event_unpacker: queue-based reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_dvs_event_unpacker;

  localparam int XB = 9;
  localparam int YB = 9;
  localparam int TB = 16;
  localparam int EW = XB + YB + 1 + TB;
  localparam int CMAX = 65535;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] in_event = '0;
  logic          in_filtered = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [XB-1:0] out_x;
  logic [YB-1:0] out_y;
  logic          out_pol;
  logic [TB-1:0] out_dt;
  logic          out_first;
  logic [15:0]   drop_count;
  logic [15:0]   fwd_count;

  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [EW-1:0] s_in_event = '0;
  logic          s_in_filtered = 1'b0;
  logic          s_out_valid;
  logic          s_out_ready = 1'b0;
  logic [XB-1:0] s_out_x;
  logic [YB-1:0] s_out_y;
  logic          s_out_pol;
  logic [TB-1:0] s_out_dt;
  logic          s_out_first;
  logic [7:0]    s_drop;
  logic [7:0]    s_fwd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dvs_event_unpacker u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_event(in_event), .in_filtered(in_filtered),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_pol(out_pol),
    .out_dt(out_dt), .out_first(out_first),
    .drop_count(drop_count), .fwd_count(fwd_count)
  );

  dvs_event_unpacker #(.CNT_BITS(8)) u_sat (
    .clk(clk), .rst(rst), .clear(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_event(s_in_event), .in_filtered(s_in_filtered),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_x(s_out_x), .out_y(s_out_y), .out_pol(s_out_pol),
    .out_dt(s_out_dt), .out_first(s_out_first),
    .drop_count(s_drop), .fwd_count(s_fwd)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int p;
    int dt;
    int first;
  } mev_t;

  mev_t mq[$];
  int   m_last  = 0;
  int   m_first = 1;
  int   m_drop  = 0;
  int   m_fwd   = 0;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_last = 0; m_first = 1; m_drop = 0; m_fwd = 0;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_x", out_x, 0);
      chk("rst_dt", out_dt, 0);
      chk("rst_first", out_first, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_fwd", fwd_count, 0);
    end else begin
      bit acc, ox, fwd_ev;
      mev_t e;
      int ts;
      chk("m_ready", in_ready, (mq.size() < 2) ? 1 : 0);
      chk("m_valid", out_valid, (mq.size() > 0) ? 1 : 0);
      if (mq.size() > 0) begin
        chk("m_x", out_x, mq[0].x);
        chk("m_y", out_y, mq[0].y);
        chk("m_pol", out_pol, mq[0].p);
        chk("m_dt", out_dt, mq[0].dt);
        chk("m_first", out_first, mq[0].first);
      end
      chk("m_drop", drop_count, m_drop);
      chk("m_fwd", fwd_count, m_fwd);
      acc = in_valid && (mq.size() < 2);
      ox = out_ready && (mq.size() > 0);
      fwd_ev = acc && !in_filtered;
      if (ox) void'(mq.pop_front());
      if (acc && in_filtered && !clear && m_drop < CMAX) m_drop++;
      if (fwd_ev) begin
        ts = int'(in_event[TB-1:0]);
        e.x = int'(in_event[EW-1:EW-XB]);
        e.y = int'(in_event[TB+YB:TB+1]);
        e.p = int'(in_event[TB]);
        e.first = (m_first || clear) ? 1 : 0;
        e.dt = e.first ? 0 : (ts - m_last + 65536) % 65536;
        mq.push_back(e);
        m_last = ts;
        m_first = 0;
        if (!clear && m_fwd < CMAX) m_fwd++;
      end
      if (clear) begin
        m_drop = 0;
        m_fwd = 0;
        if (!fwd_ev) m_first = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int x, input int y, input int p,
                     input int ts, input bit f);
    in_valid = 1'b1;
    in_filtered = f;
    in_event = {XB'(x), YB'(y), 1'(p), TB'(ts)};
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_filtered = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("reset_ready", in_ready, 1);
    chk("reset_valid", out_valid, 0);
    rst = 1'b0;
    step();

    put(5, 7, 1, 1000, 0);
    step();
    idle();
    chk("e1_valid", out_valid, 1);
    chk("e1_x", out_x, 5);
    chk("e1_y", out_y, 7);
    chk("e1_pol", out_pol, 1);
    chk("e1_dt", out_dt, 0);
    chk("e1_first", out_first, 1);
    chk("e1_fwd", fwd_count, 1);

    put(1, 2, 0, 1250, 0);
    step();
    chk("e2_dt", out_dt, 250);
    chk("e2_first", out_first, 0);
    put(3, 4, 1, 1250, 0);
    step();
    chk("e3_dt", out_dt, 0);
    chk("e3_first", out_first, 0);

    put(8, 8, 0, 3000, 1);
    step();
    chk("f1_valid", out_valid, 0);
    chk("f1_drop", drop_count, 1);
    put(9, 9, 1, 1300, 0);
    step();
    chk("f2_dt", out_dt, 50);
    chk("f2_x", out_x, 9);
    put(8, 8, 0, 9, 1);
    step();
    idle();
    chk("f3_valid", out_valid, 0);
    chk("f3_drop", drop_count, 2);
    chk("f3_fwd", fwd_count, 4);

    put(1, 1, 0, 65530, 0);
    step();
    put(2, 2, 0, 4, 0);
    step();
    idle();
    chk("wrap_dt", out_dt, 10);
    step();

    out_ready = 1'b0;
    put(10, 0, 0, 10, 0);
    chk("bp_rdy0", in_ready, 1);
    step();
    put(11, 0, 0, 20, 0);
    chk("bp_rdy1", in_ready, 1);
    step();
    put(12, 0, 0, 30, 0);
    chk("bp_rdy2", in_ready, 0);
    step();
    chk("bp_hold", out_x, 10);
    out_ready = 1'b1;
    step();
    chk("bp_b", out_x, 11);
    chk("bp_rdy3", in_ready, 1);
    step();
    idle();
    chk("bp_c", out_x, 12);
    chk("bp_cdt", out_dt, 10);
    step();
    chk("bp_empty", out_valid, 0);

    out_ready = 1'b0;
    put(20, 1, 0, 100, 0);
    step();
    put(21, 1, 0, 110, 0);
    step();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_fwd", fwd_count, 0);
    chk("clr_drop", drop_count, 0);
    chk("clr_x", out_x, 20);
    chk("clr_rdy", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("clr_e", out_x, 21);
    step();
    chk("clr_empty", out_valid, 0);
    put(22, 3, 1, 700, 0);
    step();
    chk("clr_f_first", out_first, 1);
    chk("clr_f_dt", out_dt, 0);
    chk("clr_f_fwd", fwd_count, 1);
    put(23, 3, 0, 900, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle();
    chk("clr_g_x", out_x, 23);
    chk("clr_g_first", out_first, 1);
    chk("clr_g_dt", out_dt, 0);
    chk("clr_g_fwd", fwd_count, 0);
    step();

    out_ready = 1'b0;
    put(30, 0, 0, 5, 0);
    step();
    put(31, 0, 0, 6, 0);
    step();
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_x", out_x, 0);
    chk("arst_fwd", fwd_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(3) != 0) begin
        put(int'($urandom_range(511)), int'($urandom_range(511)),
            int'($urandom_range(1)), int'($urandom_range(65535)),
            ($urandom_range(3) == 0));
      end else begin
        idle();
      end
      out_ready = ($urandom_range(2) != 0);
      clear = ($urandom_range(39) == 0);
      step();
    end
    idle();
    clear = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("drain_valid", out_valid, 0);

    s_in_valid = 1'b1;
    s_in_filtered = 1'b1;
    for (int i = 0; i < 254; i++) step();
    chk("sat_drop254", s_drop, 254);
    step();
    chk("sat_drop255", s_drop, 255);
    step();
    chk("sat_drop_hold", s_drop, 255);
    s_in_filtered = 1'b0;
    s_out_ready = 1'b1;
    for (int i = 0; i < 257; i++) step();
    chk("sat_fwd", s_fwd, 255);
    chk("sat_drop_keep", s_drop, 255);
    s_in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
